// File: rtl/branch_ctrl.sv
// Branch resolution controller: latches a branch on start, asks the ALU to compare,
// evaluates the flags and emits a fixed-latency PC load. Optional counters under BRANCH_STATS_EN.
module branch_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [5:0]  opcode,
  input  logic [15:0] offset,
  input  logic [31:0] pc_plus4,
  input  logic        igual,
  input  logic        maior,
  input  logic        menor,
  output logic        alu_start,
  output logic        busy,
  output logic        pc_write,
  output logic [31:0] pc_next,
  output logic        done,
  output logic        taken,
  output logic        err
`ifdef BRANCH_STATS_EN
  ,
  output logic [15:0] taken_cnt,
  output logic [15:0] nottaken_cnt
`endif
);

  // state   | meaning
  // S_IDLE  | waiting for start; only state that accepts a request
  // S_CMP   | ALU compare requested (alu_start)
  // S_EVAL  | ALU flags valid; condition resolved at the exit edge
  // S_WRITE | done pulse, PC load when taken
  typedef enum logic [1:0] {S_IDLE, S_CMP, S_EVAL, S_WRITE} state_t;

  state_t      state_q, state_d;
  logic [5:0]  op_q;
  logic [31:0] target_q;
  logic        taken_q, err_q;
  logic        cond;
  logic        unsup;
  logic        accept;

  assign accept = (state_q == S_IDLE) && start;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_CMP;
      S_CMP:   state_d = S_EVAL;
      S_EVAL:  state_d = S_WRITE;
      S_WRITE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Several flags high at once still resolve through exactly one table entry.
  always_comb begin
    cond  = 1'b0;
    unsup = 1'b0;
    case (op_q)
      6'd4:    cond = igual;
      6'd5:    cond = !igual;
      6'd6:    cond = !maior;
      6'd7:    cond = maior;
      6'd1:    cond = menor;
      default: unsup = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      op_q     <= 6'd0;
      target_q <= 32'd0;
      taken_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q     <= opcode;
        target_q <= pc_plus4 + {{14{offset[15]}}, offset, 2'b00};
        taken_q  <= 1'b0;
        err_q    <= 1'b0;
      end
      if (state_q == S_EVAL) begin
        taken_q <= cond && !unsup;
        err_q   <= unsup;
      end
    end
  end

  always_comb begin
    alu_start = 1'b0;
    busy      = 1'b0;
    pc_write  = 1'b0;
    done      = 1'b0;
    pc_next   = target_q;
    taken     = taken_q;
    err       = err_q;
    case (state_q)
      S_CMP: begin
        alu_start = 1'b1;
        busy      = 1'b1;
      end
      S_EVAL:  busy = 1'b1;
      S_WRITE: begin
        busy     = 1'b1;
        done     = 1'b1;
        pc_write = taken_q;
      end
      default: ;
    endcase
  end

`ifdef BRANCH_STATS_EN
  logic [15:0] taken_cnt_q, nottaken_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      taken_cnt_q    <= 16'd0;
      nottaken_cnt_q <= 16'd0;
    end else if (state_q == S_WRITE && !err_q) begin
      if (taken_q) taken_cnt_q    <= taken_cnt_q + 16'd1;
      else         nottaken_cnt_q <= nottaken_cnt_q + 16'd1;
    end
  end

  assign taken_cnt    = taken_cnt_q;
  assign nottaken_cnt = nottaken_cnt_q;
`endif

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed self-checking bench for branch_ctrl; counter checks compile in with BRANCH_STATS_EN.
module tb_branch_ctrl;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [5:0]  opcode;
  logic [15:0] offset;
  logic [31:0] pc_plus4;
  logic        igual, maior, menor;
  logic        alu_start, busy, pc_write, done, taken, err;
  logic [31:0] pc_next;
`ifdef BRANCH_STATS_EN
  logic [15:0] taken_cnt, nottaken_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int exp_tcnt = 0;
  int exp_ncnt = 0;

  always #5 clk = ~clk;

  branch_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .opcode(opcode), .offset(offset),
    .pc_plus4(pc_plus4), .igual(igual), .maior(maior), .menor(menor),
    .alu_start(alu_start), .busy(busy), .pc_write(pc_write), .pc_next(pc_next),
    .done(done), .taken(taken), .err(err)
`ifdef BRANCH_STATS_EN
    , .taken_cnt(taken_cnt), .nottaken_cnt(nottaken_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Called at a negedge with the DUT in IDLE. Flags are inverted outside EVAL and the
  // operands are scrambled after acceptance; neither may affect the result.
  task automatic run_branch(input string nm, input logic [5:0] op, input logic [15:0] off,
                            input logic [31:0] pc, input logic fi, input logic fma,
                            input logic fme, input logic exp_t, input logic exp_e,
                            input logic [31:0] exp_pc, input logic poke);
    start = 1'b1; opcode = op; offset = off; pc_plus4 = pc;
    igual = ~fi; maior = ~fma; menor = ~fme;
    step();
    chk({nm, ".cmp_alu_start"}, {31'd0, alu_start}, 32'd1);
    chk({nm, ".cmp_busy"}, {31'd0, busy}, 32'd1);
    chk({nm, ".cmp_done"}, {31'd0, done}, 32'd0);
    start = poke; opcode = ~op; offset = ~off; pc_plus4 = ~pc;
    step();
    chk({nm, ".eval_alu_start"}, {31'd0, alu_start}, 32'd0);
    chk({nm, ".eval_pc_write"}, {31'd0, pc_write}, 32'd0);
    igual = fi; maior = fma; menor = fme;
    step();
    chk({nm, ".wr_done"}, {31'd0, done}, 32'd1);
    chk({nm, ".wr_taken"}, {31'd0, taken}, {31'd0, exp_t});
    chk({nm, ".wr_err"}, {31'd0, err}, {31'd0, exp_e});
    chk({nm, ".wr_pc_write"}, {31'd0, pc_write}, {31'd0, exp_t});
    chk({nm, ".wr_alu_start"}, {31'd0, alu_start}, 32'd0);
    if (exp_t) chk({nm, ".wr_pc_next"}, pc_next, exp_pc);
    if (!exp_e) begin
      if (exp_t) exp_tcnt++;
      else       exp_ncnt++;
    end
    start = 1'b1;
    igual = ~fi; maior = ~fma; menor = ~fme;
    step();
    chk({nm, ".idle_busy"}, {31'd0, busy}, 32'd0);
    chk({nm, ".idle_done"}, {31'd0, done}, 32'd0);
    chk({nm, ".idle_taken_held"}, {31'd0, taken}, {31'd0, exp_t});
    chk({nm, ".idle_err_held"}, {31'd0, err}, {31'd0, exp_e});
    chk({nm, ".idle_pc_write"}, {31'd0, pc_write}, 32'd0);
    start = 1'b0;
    step();
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, ".alu_start"}, {31'd0, alu_start}, 32'd0);
    chk({nm, ".busy"}, {31'd0, busy}, 32'd0);
    chk({nm, ".pc_write"}, {31'd0, pc_write}, 32'd0);
    chk({nm, ".done"}, {31'd0, done}, 32'd0);
    chk({nm, ".taken"}, {31'd0, taken}, 32'd0);
    chk({nm, ".err"}, {31'd0, err}, 32'd0);
    chk({nm, ".pc_next"}, pc_next, 32'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; opcode = 6'd0; offset = 16'd0; pc_plus4 = 32'd0;
    igual = 1'b0; maior = 1'b0; menor = 1'b0;
    step();
    step();
    chk_all_zero("reset");
    reset = 1'b0;
    step();

    //          name        op     off       pc            i  M  m  tk er exp_pc        poke
    run_branch("beq",      6'd4,  16'h0003, 32'h00000100, 1, 0, 0, 1, 0, 32'h0000010C, 0);
    run_branch("bne_bk",   6'd5,  16'hFFFE, 32'h00000100, 0, 0, 0, 1, 0, 32'h000000F8, 0);
    run_branch("bne_nt",   6'd5,  16'hFFFE, 32'h00000100, 1, 0, 0, 0, 0, 32'h000000F8, 0);
    run_branch("op6",      6'd6,  16'h0010, 32'h00001000, 0, 1, 0, 0, 0, 32'h00001040, 0);
    run_branch("op7",      6'd7,  16'h0010, 32'h00001000, 0, 1, 0, 1, 0, 32'h00001040, 0);
    run_branch("op1",      6'd1,  16'h8000, 32'h00040000, 0, 0, 1, 1, 0, 32'h00020000, 0);
    run_branch("unsup23",  6'h23, 16'h0004, 32'h00000200, 1, 1, 1, 0, 1, 32'h00000210, 1);
    run_branch("wrap",     6'd4,  16'h0001, 32'hFFFFFFFC, 1, 0, 0, 1, 0, 32'h00000000, 1);
    run_branch("multi4",   6'd4,  16'h0002, 32'h00000400, 1, 1, 1, 1, 0, 32'h00000408, 0);
    run_branch("multi6",   6'd6,  16'h0002, 32'h00000400, 0, 0, 1, 1, 0, 32'h00000408, 0);
    run_branch("multi7nt", 6'd7,  16'h0002, 32'h00000400, 1, 0, 1, 0, 0, 32'h00000408, 0);
    run_branch("unsup0",   6'd0,  16'h0002, 32'h00000400, 1, 1, 1, 0, 1, 32'h00000408, 0);

`ifdef BRANCH_STATS_EN
    chk("stats.taken_cnt", {16'd0, taken_cnt}, exp_tcnt[31:0]);
    chk("stats.nottaken_cnt", {16'd0, nottaken_cnt}, exp_ncnt[31:0]);
`endif

    // Abort a taken branch from EVAL: no done, no pc_write, everything cleared.
    start = 1'b1; opcode = 6'd4; offset = 16'h0003; pc_plus4 = 32'h00000100;
    step();
    start = 1'b0;
    step();
    igual = 1'b1;
    chk("abort.pre_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    step();
    chk_all_zero("abort");
    reset = 1'b0;
    step();
    chk("abort.after_done", {31'd0, done}, 32'd0);
    chk("abort.after_pc_write", {31'd0, pc_write}, 32'd0);
    chk("abort.after_busy", {31'd0, busy}, 32'd0);
`ifdef BRANCH_STATS_EN
    chk("abort.taken_cnt", {16'd0, taken_cnt}, 32'd0);
    chk("abort.nottaken_cnt", {16'd0, nottaken_cnt}, 32'd0);
`endif

    run_branch("post_rst", 6'd4, 16'h0003, 32'h00000100, 1, 0, 0, 1, 0, 32'h0000010C, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
